// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war field controller: game states and the
// encoding of the last-round winner.
package tow_pkg;

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      ROUND_OVER = 2'd1,
      MATCH_OVER = 2'd2
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/tow_edge_detect.sv
// Rising-edge detector for W synchronised levels. History resets to all-ones
// so a level already high when reset releases never reads as a fresh press.
module tow_edge_detect #(
   parameter int W = 2
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [W-1:0] level_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] prev_q;
   logic [W-1:0] prev_d;

   always_comb begin
      prev_d = level_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         prev_q <= '1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/tow_field_ctrl.sv
// Tug-of-war controller: moves a one-hot rope marker on each net button press,
// scores round wins and latches the end of the match until reset.
module tow_field_ctrl
   import tow_pkg::*;
#(
   parameter int NUM_LEDS   = 9,
   parameter int SCORE_W    = 3,
   parameter int MATCH_WINS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                player1,
   input  logic                player2,
   input  logic                restart,
   output logic [NUM_LEDS-1:0] leds,
   output logic [1:0]          winner,
   output logic [SCORE_W-1:0]  score1,
   output logic [SCORE_W-1:0]  score2,
   output logic                match_over,
   output logic [1:0]          dbg_state_o
);

   localparam int                PW        = $clog2(NUM_LEDS);
   localparam logic [PW-1:0]     POS_C     = PW'((NUM_LEDS - 1) / 2);
   localparam logic [PW-1:0]     POS_MAX   = PW'(NUM_LEDS - 1);
   localparam logic [PW-1:0]     POS_MIN   = '0;
   localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(MATCH_WINS);

   logic [1:0]         press;
   logic               p1_only;
   logic               p2_only;

   state_e             state_q,  state_d;
   logic [PW-1:0]      pos_q,    pos_d;
   logic [1:0]         winner_q, winner_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [SCORE_W-1:0] score2_q, score2_d;

   tow_edge_detect #(
      .W (2)
   ) u_edge (
      .clk_i   (clk),
      .reset_i (reset),
      .level_i ({player2, player1}),
      .rise_o  (press)
   );

   // Simultaneous presses cancel, so only a lone press moves the rope.
   assign p1_only = press[0] & ~press[1];
   assign p2_only = press[1] & ~press[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= PLAY;
         pos_q    <= POS_C;
         winner_q <= WIN_NONE;
         score1_q <= '0;
         score2_q <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         winner_q <= winner_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      winner_d = winner_q;
      score1_d = score1_q;
      score2_d = score2_q;
      unique case (state_q)
         PLAY: begin
            // Restart takes priority over any press on the same edge.
            if (restart) begin
               pos_d = POS_C;
            end else if (p1_only) begin
               if (pos_q == POS_MAX) begin
                  winner_d = WIN_P1;
                  score1_d = score1_q + SCORE_W'(1);
                  state_d  = (score1_d == SCORE_WIN) ? MATCH_OVER : ROUND_OVER;
               end else begin
                  pos_d = pos_q + PW'(1);
               end
            end else if (p2_only) begin
               if (pos_q == POS_MIN) begin
                  winner_d = WIN_P2;
                  score2_d = score2_q + SCORE_W'(1);
                  state_d  = (score2_d == SCORE_WIN) ? MATCH_OVER : ROUND_OVER;
               end else begin
                  pos_d = pos_q - PW'(1);
               end
            end
         end
         ROUND_OVER: begin
            if (restart) begin
               pos_d    = POS_C;
               winner_d = WIN_NONE;
               state_d  = PLAY;
            end
         end
         MATCH_OVER: begin
            state_d = MATCH_OVER;
         end
         default: begin
            state_d = PLAY;
         end
      endcase
   end

   always_comb begin
      leds        = '0;
      if (state_q == PLAY) begin
         leds = NUM_LEDS'(1) << pos_q;
      end
      winner      = winner_q;
      score1      = score1_q;
      score2      = score2_q;
      match_over  = (state_q == MATCH_OVER);
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_tow_field_ctrl.sv
// Bench for tow_field_ctrl: a game-level reference model predicts the visible
// outputs after every clock; a monitor compares them against the design.
module tb_tow_field_ctrl;

  localparam int N  = 5;
  localparam int SW = 3;
  localparam int MW = 2;
  localparam int C  = (N - 1) / 2;
  localparam int OW = N + 2 + SW + SW + 1 + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, player1, player2, restart;
  logic [N-1:0]  leds;
  logic [1:0]    winner;
  logic [SW-1:0] score1, score2;
  logic          match_over;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  tow_field_ctrl #(
    .NUM_LEDS   (N),
    .SCORE_W    (SW),
    .MATCH_WINS (MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .player1     (player1),
    .player2     (player2),
    .restart     (restart),
    .leds        (leds),
    .winner      (winner),
    .score1      (score1),
    .score2      (score2),
    .match_over  (match_over),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mon_idx = 0;

  // Game-level model: rope position, whether a round is live, match finished.
  int m_pos, m_win, m_s1, m_s2;
  bit m_play, m_done, m_prev1, m_prev2;

  function automatic logic [OW-1:0] pack_exp();
    logic [N-1:0] l;
    logic [1:0]   st;
    l  = m_play ? (N'(1) << m_pos) : '0;
    st = m_play ? 2'd0 : (m_done ? 2'd2 : 2'd1);
    return {l, 2'(m_win), SW'(m_s1), SW'(m_s2), m_done, st};
  endfunction

  function automatic logic [OW-1:0] pack_dut();
    return {leds, winner, score1, score2, match_over, dbg_state};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got leds=%b win=%b s1=%0d s2=%0d mo=%b st=%0d, expected leds=%b win=%b s1=%0d s2=%0d mo=%b st=%0d",
               name, got[OW-1 -: N], got[10:9], got[8:6], got[5:3], got[2], got[1:0],
               exp[OW-1 -: N], exp[10:9], exp[8:6], exp[5:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic model_reset();
    m_pos = C; m_win = 0; m_s1 = 0; m_s2 = 0;
    m_play = 1'b1; m_done = 1'b0;
    m_prev1 = 1'b1; m_prev2 = 1'b1;
  endtask

  task automatic model_step(input bit p1, input bit p2, input bit rs);
    bit pr1, pr2;
    pr1 = p1 && !m_prev1;
    pr2 = p2 && !m_prev2;
    m_prev1 = p1;
    m_prev2 = p2;
    if (m_play) begin
      if (rs) begin
        m_pos = C;
      end else if (pr1 && !pr2) begin
        if (m_pos == N - 1) begin
          m_s1++; m_win = 1; m_play = 1'b0; m_done = (m_s1 == MW);
        end else begin
          m_pos++;
        end
      end else if (pr2 && !pr1) begin
        if (m_pos == 0) begin
          m_s2++; m_win = 2; m_play = 1'b0; m_done = (m_s2 == MW);
        end else begin
          m_pos--;
        end
      end
    end else if (!m_done && rs) begin
      m_play = 1'b1; m_pos = C; m_win = 0;
    end
    exp_q.push_back(pack_exp());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit p1, input bit p2, input bit rs);
    @(negedge clk);
    player1 = p1;
    player2 = p2;
    restart = rs;
    model_step(p1, p2, rs);
  endtask

  task automatic pulse(input bit p1, input bit p2);
    drive(p1, p2, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Reset lands between clock edges; outputs must clear before the next edge.
  task automatic async_reset(input bit hold_p1);
    @(negedge clk);
    #2;
    player1 = hold_p1;
    player2 = 1'b0;
    restart = 1'b0;
    reset   = 1'b1;
    #1;
    check("async_reset", pack_dut(), {5'b00100, 2'b00, 3'd0, 3'd0, 1'b0, 2'd0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    model_step(hold_p1, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d", mon_idx), pack_dut(), e);
        mon_idx++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; player1 = 1'b0; player2 = 1'b0; restart = 1'b0;
    model_reset();

    // Held button through reset release is not a press.
    async_reset(1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // First round win for player1, then ignored presses, then restart.
    repeat (3) pulse(1'b1, 1'b0);
    repeat (3) pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Second win ends the match; everything after is ignored.
    repeat (3) pulse(1'b1, 1'b0);
    repeat (10) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);

    // Reset mid-round.
    async_reset(1'b0);
    repeat (2) pulse(1'b0, 1'b1);
    async_reset(1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Random play with occasional restarts and resets.
    repeat (800) begin
      if ($urandom_range(0, 99) == 0)
        async_reset(1'($urandom_range(0, 1)));
      else
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
